// File: rtl/vga_sync_monitor_if.sv
// Tap bundle between the VGA pins of the game top-level and the sync monitor.
// The master side drives the sampled pins; the slave side is the monitor.
interface vga_sync_monitor_if;
  logic        pix_en;
  logic        HS_L;
  logic        VS_L;
  logic [7:0]  rgb;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [15:0] frame_cnt;
  logic [7:0]  cap_pix;
  logic        err;

  modport master (
    output pix_en, HS_L, VS_L, rgb,
    input  x, y, active, locked, frame_done, frame_sum, frame_cnt, cap_pix, err
  );

  modport slave (
    input  pix_en, HS_L, VS_L, rgb,
    output x, y, active, locked, frame_done, frame_sum, frame_cnt, cap_pix, err
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA checker: recovers sync timing, locks onto clean frames and
// reports coordinates, a per-frame colour checksum and one probe pixel.
// Position convention: the tick that samples an HS_L falling edge is hcnt 0,
// and the line containing the VS_L falling edge is vcnt 0.
module vga_sync_monitor #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int CAP_X    = 320,
  parameter int CAP_Y    = 240
) (
  input  logic              clk,
  input  logic              rst_L,
  vga_sync_monitor_if.slave mon
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] H_MAX       = 11'h7FF;
  localparam logic [9:0]  V_MAX       = 10'h3FF;
  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_LAST = 11'(H_SYNC - 1);
  localparam logic [10:0] H_START     = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END       = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] H_CAP       = 11'(H_SYNC + H_BP + CAP_X);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_LN   = 10'(V_SYNC);
  localparam logic [9:0]  V_START     = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END       = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  V_CAP       = 10'(V_SYNC + V_BP + CAP_Y);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == H_MAX) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == V_MAX) ? v : v + 10'd1;
  endfunction

  // Stage p0: previously sampled sync levels and timing counters
  logic        hs_p0, vs_p0, vs_pend_p0;
  logic [10:0] hcnt_p0;
  logic [9:0]  vcnt_p0, vs_lines_p0;

  // Stage p1: registered coordinates, accumulators and reported results
  state_t      state_q;
  logic [9:0]  x_p1;
  logic [8:0]  y_p1;
  logic        active_p1, frame_done_p1, err_p1;
  logic [15:0] sum_p1, frame_sum_p1, frame_cnt_p1;
  logic [7:0]  cap_lat_p1, cap_pix_p1;

  logic        hs_fall, hs_rise, vs_fall, vs_rise, v_zero, h_sat, v_sat;
  logic        mismatch, in_win, cap_hit, vs_pend_nx;
  logic [10:0] hcnt_nx;
  logic [9:0]  vcnt_nx, vs_lines_nx;

  // Edge detection, next counter values and the per-tick timing mismatch
  always_comb begin
    hs_fall    = hs_p0 & ~mon.HS_L;
    hs_rise    = ~hs_p0 & mon.HS_L;
    vs_fall    = vs_p0 & ~mon.VS_L;
    vs_rise    = ~vs_p0 & mon.VS_L;
    hcnt_nx    = hs_fall ? 11'd0 : sat_inc11(hcnt_p0);
    h_sat      = ~hs_fall & (hcnt_p0 == H_MAX);
    v_zero     = hs_fall & (vs_fall | vs_pend_p0);
    vcnt_nx    = vcnt_p0;
    if (v_zero)       vcnt_nx = 10'd0;
    else if (hs_fall) vcnt_nx = sat_inc10(vcnt_p0);
    v_sat      = hs_fall & ~v_zero & (vcnt_p0 == V_MAX);
    vs_pend_nx = hs_fall ? 1'b0 : (vs_fall | vs_pend_p0);
    vs_lines_nx = vs_lines_p0;
    if (vs_fall)                     vs_lines_nx = {9'd0, hs_fall};
    else if (hs_fall & ~mon.VS_L)    vs_lines_nx = sat_inc10(vs_lines_p0);
    mismatch   = (hs_fall & (hcnt_p0 != H_LAST))
               | (hs_rise & (hcnt_p0 != H_SYNC_LAST))
               | (vs_rise & (vs_lines_p0 != V_SYNC_LN))
               | (vs_fall & (vcnt_p0 != V_LAST))
               | h_sat | v_sat;
    in_win     = (hcnt_nx >= H_START) && (hcnt_nx <= H_END) &&
                 (vcnt_nx >= V_START) && (vcnt_nx <= V_END);
    cap_hit    = (hcnt_nx == H_CAP) && (vcnt_nx == V_CAP);
  end

  // Sync sampling, timing counters and coordinates, advanced once per pixel tick
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      hs_p0       <= 1'b0;
      vs_p0       <= 1'b0;
      vs_pend_p0  <= 1'b0;
      hcnt_p0     <= '0;
      vcnt_p0     <= '0;
      vs_lines_p0 <= '0;
      x_p1        <= '0;
      y_p1        <= '0;
    end else if (mon.pix_en) begin
      hs_p0       <= mon.HS_L;
      vs_p0       <= mon.VS_L;
      vs_pend_p0  <= vs_pend_nx;
      hcnt_p0     <= hcnt_nx;
      vcnt_p0     <= vcnt_nx;
      vs_lines_p0 <= vs_lines_nx;
      if (in_win) begin
        x_p1 <= 10'(hcnt_nx - H_START);
        y_p1 <= 9'(vcnt_nx - V_START);
      end
    end
  end

  // Lock FSM with frame accumulation and result reporting
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q       <= SEARCH;
      active_p1     <= 1'b0;
      frame_done_p1 <= 1'b0;
      err_p1        <= 1'b0;
      sum_p1        <= '0;
      frame_sum_p1  <= '0;
      frame_cnt_p1  <= '0;
      cap_lat_p1    <= '0;
      cap_pix_p1    <= '0;
    end else begin
      frame_done_p1 <= 1'b0;
      if (mon.pix_en) begin
        active_p1 <= 1'b0;
        case (state_q)
          SEARCH: begin
            if (vs_fall) begin
              state_q    <= ACQUIRE;
              sum_p1     <= '0;
              cap_lat_p1 <= '0;
            end
          end
          ACQUIRE: begin
            if (mismatch) begin
              state_q <= SEARCH;
            end else if (vs_fall) begin
              state_q    <= LOCKED;
              sum_p1     <= '0;
              cap_lat_p1 <= '0;
            end
          end
          LOCKED: begin
            if (mismatch) begin
              state_q <= SEARCH;
              err_p1  <= 1'b1;
              sum_p1  <= '0;
            end else begin
              active_p1 <= in_win;
              if (in_win)  sum_p1     <= sum_p1 + {8'd0, mon.rgb};
              if (cap_hit) cap_lat_p1 <= mon.rgb;
              if (vs_fall) begin
                frame_sum_p1  <= sum_p1;
                cap_pix_p1    <= cap_lat_p1;
                frame_cnt_p1  <= frame_cnt_p1 + 16'd1;
                frame_done_p1 <= 1'b1;
                sum_p1        <= '0;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign mon.x          = x_p1;
  assign mon.y          = y_p1;
  assign mon.active     = active_p1;
  assign mon.locked     = (state_q == LOCKED);
  assign mon.frame_done = frame_done_p1;
  assign mon.frame_sum  = frame_sum_p1;
  assign mon.frame_cnt  = frame_cnt_p1;
  assign mon.cap_pix    = cap_pix_p1;
  assign mon.err        = err_p1;

endmodule
